// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, access-slot encoding and lane-mask helper for the register-file front end.
package regfile_pkg;
    localparam int LANES        = 8;
    localparam int DATA_W       = 64;
    localparam int ADDR_W       = 6;
    localparam int WARP_W       = 3;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_WR, SLOT_RD} slot_e;

    function automatic logic [LANES*DATA_W-1:0] lane_mask(input logic [LANES*DATA_W-1:0] d,
                                                          input logic [LANES-1:0] m);
        logic [LANES*DATA_W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = m[l] ? d[l*DATA_W +: DATA_W] : '0;
        return r;
    endfunction
endpackage

// File: rtl/regfile_op_buffer.sv
// regfile_op_buffer: one-entry valid/ready operand holding register; disabled lanes are stored as zero.
module regfile_op_buffer
    import regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_i,
    input  logic [WARP_W-1:0]       warp_i,
    input  logic [LANES-1:0]        mask_i,
    input  logic [LANES*DATA_W-1:0] a_i,
    input  logic [LANES*DATA_W-1:0] b_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [WARP_W-1:0]       warp_o,
    output logic [LANES-1:0]        mask_o,
    output logic [LANES*DATA_W-1:0] a_o,
    output logic [LANES*DATA_W-1:0] b_o
);
    logic                    full_q, full_d;
    logic [WARP_W-1:0]       warp_q, warp_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic [LANES*DATA_W-1:0] a_q, a_d, b_q, b_d;

    always_comb begin
        full_d = cap_i | (full_q & ~ready_i);
        warp_d = cap_i ? warp_i : warp_q;
        mask_d = cap_i ? mask_i : mask_q;
        a_d    = cap_i ? lane_mask(a_i, mask_i) : a_q;
        b_d    = cap_i ? lane_mask(b_i, mask_i) : b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            warp_q <= '0;
            mask_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            full_q <= full_d;
            warp_q <= warp_d;
            mask_q <= mask_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    assign valid_o = full_q;
    assign warp_o  = warp_q;
    assign mask_o  = mask_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: arbitrates writeback and operand reads onto register_block, one registered slot per cycle.
// REGFILE_ACCESS_FAIRNESS_EN: forces a pending read after STARVE_LIMIT consecutive write grants.
module regfile_access_ctrl
    import regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [WARP_W-1:0]       wb_warp,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [LANES-1:0]        wb_mask,
    input  logic [LANES*DATA_W-1:0] wb_data,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [WARP_W-1:0]       rd_warp,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    input  logic [LANES-1:0]        rd_mask,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [WARP_W-1:0]       op_warp,
    output logic [LANES-1:0]        op_mask,
    output logic [LANES*DATA_W-1:0] op_a,
    output logic [LANES*DATA_W-1:0] op_b,
    output logic [WARP_W-1:0]       rf_warp_selector,
    output logic [LANES-1:0]        rf_write_en,
    output logic [ADDR_W-1:0]       rf_waddr,
    output logic [LANES*DATA_W-1:0] rf_wdata,
    output logic [LANES-1:0]        rf_read_en_0,
    output logic [LANES-1:0]        rf_read_en_1,
    output logic [ADDR_W-1:0]       rf_raddr_0,
    output logic [ADDR_W-1:0]       rf_raddr_1,
    input  logic [LANES*DATA_W-1:0] rf_rdata_0,
    input  logic [LANES*DATA_W-1:0] rf_rdata_1
);
    slot_e                   slot_q, slot_d;
    logic [WARP_W-1:0]       warp_q, warp_d;
    logic [ADDR_W-1:0]       a_q, a_d, b_q, b_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
    logic                    force_rd, wr_hs, rd_hs;

`ifdef REGFILE_ACCESS_FAIRNESS_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign force_rd = cnt_q >= CW'(STARVE_LIMIT);
    // Stays saturated until the read actually wins, so a busy buffer cannot lose the forced slot.
    always_comb cnt_d = (!rd_valid || rd_hs) ? '0 : cnt_q + CW'(wr_hs);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign force_rd = 1'b0;
`endif

    assign wb_ready = !rst && !force_rd;
    assign wr_hs    = wb_valid && wb_ready;
    // A read slot captures into the buffer next cycle, so it must be empty or draining now.
    assign rd_ready = !rst && !wr_hs && slot_q != SLOT_RD && (!op_valid || op_ready);
    assign rd_hs    = rd_valid && rd_ready;

    always_comb begin
        slot_d  = wr_hs ? SLOT_WR : rd_hs ? SLOT_RD : SLOT_IDLE;
        warp_d  = wr_hs ? wb_warp : rd_hs ? rd_warp : '0;
        a_d     = wr_hs ? wb_addr : rd_hs ? rd_addr_a : '0;
        b_d     = rd_hs ? rd_addr_b : '0;
        mask_d  = wr_hs ? wb_mask : rd_hs ? rd_mask : '0;
        wdata_d = wr_hs ? wb_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= SLOT_IDLE;
            warp_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
        end else begin
            slot_q  <= slot_d;
            warp_q  <= warp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_warp_selector = warp_q;
    assign rf_write_en      = slot_q == SLOT_WR ? mask_q : '0;
    assign rf_waddr         = slot_q == SLOT_WR ? a_q : '0;
    assign rf_wdata         = wdata_q;
    assign rf_read_en_0     = slot_q == SLOT_RD ? mask_q : '0;
    assign rf_read_en_1     = rf_read_en_0;
    assign rf_raddr_0       = slot_q == SLOT_RD ? a_q : '0;
    assign rf_raddr_1       = b_q;

    regfile_op_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (slot_q == SLOT_RD),
        .warp_i  (warp_q),
        .mask_i  (mask_q),
        .a_i     (rf_rdata_0),
        .b_i     (rf_rdata_1),
        .ready_i (op_ready),
        .valid_o (op_valid),
        .warp_o  (op_warp),
        .mask_o  (op_mask),
        .a_o     (op_a),
        .b_o     (op_b)
    );
endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Front-end controller that owns every control input of `register_block`: it arbitrates a writeback channel and an operand-read channel onto the block's single shared `warp_selector`, issues one registered access per cycle, and returns both read operands for all lanes through a one-entry output buffer with a valid/ready handshake. It sits between issue/writeback logic and `register_block`, driving the signals the bench drives today.

## Interface
- `LANES`, 8, lanes per warp
- `DATA_W`, 64, register width
- `ADDR_W`, 6, register address width (64 registers)
- `WARP_W`, 3, warp index width (8 warps)
- `STARVE_LIMIT`, 4, consecutive write grants before a pending read is forced (fairness build only)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset: one clock, synchronous, active-high
- `wb_valid` / `wb_ready`  in / out  1  writeback handshake
- `wb_warp`, `wb_addr`, `wb_mask`, `wb_data`  in  WARP_W / ADDR_W / LANES / LANES*DATA_W  write target, lane enables, data (lane i at `[i*DATA_W +: DATA_W]`)
- `rd_valid` / `rd_ready`  in / out  1  operand-read handshake
- `rd_warp`, `rd_addr_a`, `rd_addr_b`, `rd_mask`  in  WARP_W / ADDR_W / ADDR_W / LANES  read target, lane enables
- `op_valid` / `op_ready`  out / in  1  operand output handshake
- `op_warp`, `op_mask`  out  WARP_W / LANES  echoed from request
- `op_a`, `op_b`  out  LANES*DATA_W  port-0 / port-1 operands
- `rf_warp_selector`  out  WARP_W
- `rf_write_en`, `rf_waddr`, `rf_wdata`  out  LANES / ADDR_W / LANES*DATA_W
- `rf_read_en_0`, `rf_read_en_1`, `rf_raddr_0`, `rf_raddr_1`  out  LANES / LANES / ADDR_W / ADDR_W
- `rf_rdata_0`, `rf_rdata_1`  in  LANES*DATA_W  combinational read data from `register_block`

## Operation
- Access slot register, states SLOT_IDLE / SLOT_WR / SLOT_RD; loaded each cycle from the granted request, else SLOT_IDLE.
- Grant: write wins when `wb_valid`; read granted when no write is granted, the slot does not hold SLOT_RD, and the buffer is empty or `op_ready` is high. `wb_ready`/`rd_ready` are the grants; a handshake occurs on `valid && ready`.
- SLOT_WR: `rf_write_en=wb_mask`, `rf_waddr`, `rf_wdata`, `rf_warp_selector=wb_warp` driven from registers; read enables 0. The write commits in `register_block` at the end of that cycle.
- SLOT_RD: `rf_read_en_0=rf_read_en_1=rd_mask`, `rf_raddr_0=rd_addr_a`, `rf_raddr_1=rd_addr_b`, `rf_warp_selector=rd_warp`; `rf_write_en=0`. `rf_rdata_*` captured into the buffer at the end of the cycle; lanes with mask bit 0 are zeroed.
- Buffer states EMPTY/FULL; FULL holds `op_*` stable until `op_ready`. Capture and drain in the same cycle are legal.
- A mask of 0 is still a legal request and occupies one slot.
- Reset: slot to SLOT_IDLE, buffer to EMPTY, starvation counter to 0, every output 0. A request in flight when `rst` rises is dropped and no write is issued.

## Timing
- Write: handshake in cycle N, `rf_write_en` in N+1, data readable by a read slot in N+2.
- Read: handshake in N, `rf_*` read controls in N+1, `op_valid` in N+2.
- Read throughput: at most one read per 2 cycles.
- Write-then-read to the same register in back-to-back handshakes returns the new data, with no bypass needed.
- Write throughput: 1 per cycle.

## Configuration
- `REGFILE_ACCESS_FAIRNESS_EN` defined: a counter tracks consecutive write grants while `rd_valid` is high. At `STARVE_LIMIT`, the next slot goes to the read (if the buffer rule allows) and `wb_ready` is held low for that cycle. The counter clears on any read grant or when `rd_valid` is low.
- Undefined: strict write priority; reads can starve indefinitely.

## Structure
- `regfile_pkg`: LANES/DATA_W/ADDR_W/WARP_W constants and the `slot_e` enum.
- Sub-module `regfile_op_buffer` (one-entry valid/ready holding register with lane-mask zeroing).
- The slot FSM and arbiter stay in the top level.

## Test plan
- Reset: hold `rst` for 2 cycles with `wb_valid=1` -> all `rf_*` and `op_valid` are 0 during reset and in the first cycle after; no write issued.
- Write warp 3, addr 6'h15, mask 8'hFF, lane i data 64'hA0+i, then read a=b=6'h15 from warp 3 -> `op_a`=`op_b`, lane i = 64'hA0+i, `op_valid` 2 cycles after the read handshake.
- Read with mask 8'h0F -> lanes 4-7 of `op_a`/`op_b` = 0; `rf_read_en_0`=8'h0F.
- Hold `op_ready=0` over two reads -> the first operand is held stable, `rd_ready=0` until the drain, and the second result is correct after `op_ready` rises.
- Simultaneous `wb_valid`/`rd_valid` for 6 cycles -> without the macro, 6 writes and then the read; with `REGFILE_ACCESS_FAIRNESS_EN`, `STARVE_LIMIT=4`, 4 writes, the read, then 2 writes.
- Sweep all 8 warps × 64 addresses with random data, write then read -> every `op_a`/`op_b` lane matches, and `rf_warp_selector` equals the request warp in each slot.
